div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 207 ++++++++++++++++++++
 tb/tb_div_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative RISC-V M-extension divider (DIV, DIVU, REM, REMU).
//
// Radix-2 restoring division on operand magnitudes. The unit produces one
// quotient bit per cycle and applies the sign fix-up on the last iteration.
// A zero divisor and signed overflow skip the iteration and finish on the
// cycle after acceptance.
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   rst_n     in   asynchronous active-low reset
//   instr     in   32-bit instruction word, decoded only when a request is accepted
//   a_in      in   dividend (rs1)
//   b_in      in   divisor (rs2)
//   valid_in  in   request valid
//   ready_out out  high when idle and able to accept a request
//   flush     in   abandon the in-flight operation; wins over valid_in
//   c_out     out  result (rd); holds the last delivered result
//   valid_out out  one-cycle pulse marking c_out valid
//
// Optional feature: define DIV_RESULT_REUSE_EN to add a one-entry result cache.
// An accept whose operands and signedness match the cached entry completes
// on the next cycle.

module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic            flush,
    output logic [XLEN-1:0] c_out,
    output logic            valid_out
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [4:0] LastIter = 5'(XLEN - 1);

    logic [1:0]      state_q, state_d;
    logic [4:0]      cnt_q;
    logic [XLEN-1:0] quo_q;     // dividend shifts out the top, quotient shifts in the bottom
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] b_mag_q;
    logic [XLEN-1:0] c_hold_q;
    logic            op_rem_q, neg_q_q, neg_r_q;

    logic            legal, accept, is_uns, is_rem, a_neg, b_neg;
    logic            div_zero, sgn_ovf, cache_hit, q_bit;
    logic [XLEN-1:0] a_mag, b_mag, q_next, r_next, q_fix, r_fix, result;
    logic [XLEN-1:0] hit_quo, hit_rem;
    logic [XLEN:0]   rem_shift;
    logic [XLEN+1:0] diff;
    logic            unused_bits;

    // Decode and operand preparation
    assign legal  = (instr[6:0] == 7'b0110011) && (instr[31:25] == 7'b0000001) && instr[14];
    assign is_uns = instr[12];
    assign is_rem = instr[13];
    assign accept = valid_in && (state_q == StIdle) && !flush && legal;

    assign a_neg    = !is_uns && a_in[XLEN-1];
    assign b_neg    = !is_uns && b_in[XLEN-1];
    assign a_mag    = a_neg ? -a_in : a_in;
    assign b_mag    = b_neg ? -b_in : b_in;
    assign div_zero = (b_in == '0);
    assign sgn_ovf  = !is_uns && (a_in == {1'b1, {(XLEN-1){1'b0}}}) && (b_in == '1);

    // One restoring step; an extra top bit keeps the borrow unambiguous
    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign diff      = {1'b0, rem_shift} - {2'b00, b_mag_q};
    assign q_bit     = ~diff[XLEN+1];
    assign r_next    = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    assign q_next    = {quo_q[XLEN-2:0], q_bit};
    assign q_fix     = neg_q_q ? -q_next : q_next;
    assign r_fix     = neg_r_q ? -r_next : r_next;

    assign result    = op_rem_q ? rem_q : quo_q;
    assign ready_out = (state_q == StIdle);
    assign valid_out = (state_q == StDone) && !flush;
    // A flush in DONE suppresses delivery, so c_out keeps the previous result
    assign c_out     = valid_out ? result : c_hold_q;

    assign unused_bits = ^{instr[24:15], instr[11:7], diff[XLEN]};

`ifdef DIV_RESULT_REUSE_EN
    logic            cache_vld_q, key_uns_q;
    logic [XLEN-1:0] key_a_q, key_b_q, cache_quo_q, cache_rem_q;

    assign cache_hit = cache_vld_q && (key_a_q == a_in) && (key_b_q == b_in)
                       && (key_uns_q == is_uns);
    assign hit_quo   = cache_quo_q;
    assign hit_rem   = cache_rem_q;

    // Key is captured at accept; the entry becomes valid once its result is delivered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld_q <= 1'b0;
            key_uns_q   <= 1'b0;
            key_a_q     <= '0;
            key_b_q     <= '0;
            cache_quo_q <= '0;
            cache_rem_q <= '0;
        end else if ((state_q == StCalc) && flush) begin
            cache_vld_q <= 1'b0;
        end else if (accept && !cache_hit) begin
            cache_vld_q <= 1'b0;
            key_a_q     <= a_in;
            key_b_q     <= b_in;
            key_uns_q   <= is_uns;
        end else if (valid_out) begin
            cache_vld_q <= 1'b1;
            cache_quo_q <= quo_q;
            cache_rem_q <= rem_q;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_quo   = '0;
    assign hit_rem   = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (div_zero || sgn_ovf || cache_hit) ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_q == LastIter) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            b_mag_q  <= '0;
            c_hold_q <= '0;
            op_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_rem_q <= is_rem;
                        cnt_q    <= '0;
                        if (div_zero) begin
                            quo_q <= '1;
                            rem_q <= a_in;
                        end else if (sgn_ovf) begin
                            quo_q <= a_in;
                            rem_q <= '0;
                        end else if (cache_hit) begin
                            quo_q <= hit_quo;
                            rem_q <= hit_rem;
                        end else begin
                            quo_q   <= a_mag;
                            rem_q   <= '0;
                            b_mag_q <= b_mag;
                            neg_q_q <= a_neg ^ b_neg;
                            neg_r_q <= a_neg;
                        end
                    end
                end
                StCalc: begin
                    if (flush) begin
                        cnt_q <= '0;
                    end else if (cnt_q == LastIter) begin
                        cnt_q <= '0;
                        quo_q <= q_fix;
                        rem_q <= r_fix;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        quo_q <= q_next;
                        rem_q <= r_next;
                    end
                end
                StDone: begin
                    if (!flush) begin
                        c_hold_q <= result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit, plus a short random run against
// a behavioural model. Define DIV_RESULT_REUSE_EN to match a cached RTL build.

module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr, a_in, b_in, c_out;
    logic        valid_in, flush, ready_out, valid_out;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [7:0]  lat;
    } vec_t;

    always #5 clk = ~clk;

    div_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .a_in      (a_in),
        .b_in      (b_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .flush     (flush),
        .c_out     (c_out),
        .valid_out (valid_out)
    );

    function automatic logic [31:0] enc(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f3[1] ? 32'h0 : 32'h8000_0000;
        case (f3)
            F_DIV:   return sa / sb;
            F_DIVU:  return a / b;
            F_REM:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    // Issue one request and wait (bounded) for its result. lat counts cycles
    // from acceptance to valid_out (1 = the cycle right after acceptance);
    // lat stays 0 on timeout. rdy_busy counts waiting cycles with ready_out=1.
    task automatic run_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int rdy_busy);
        int waited = 0;
        @(negedge clk);
        while (!ready_out && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        instr    = ins;
        a_in     = a;
        b_in     = b;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        a_in     = 32'hDEAD_BEEF;
        b_in     = 32'h1234_5678;
        lat      = 0;
        res      = '0;
        rdy_busy = 0;
        for (int i = 1; i <= 100; i++) begin
            if (valid_out) begin
                lat = i;
                res = c_out;
                break;
            end
            if (ready_out) rdy_busy++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; valid_in = 1'b0; flush = 1'b0;
        instr = '0; a_in = '0; b_in = '0;
        #3;
        n_checks++;
        if (ready_out !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", ready_out);
        end
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out);
        end
        n_checks++;
        if (c_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_cout: got %h want 00000000", c_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_divu;
        logic [31:0] res;
        int lat, busy;
        run_op(enc(F_DIVU), 32'd100, 32'd7, res, lat, busy);
        n_checks++;
        if (res !== 32'd14) begin n_fail++; $display("FAIL divu_res: got %h want 0000000e", res); end
        n_checks++;
        if (lat != 33) begin n_fail++; $display("FAIL divu_lat: got %0d want 33", lat); end
        n_checks++;
        if (busy != 0) begin n_fail++; $display("FAIL divu_busy_ready: got %0d want 0", busy); end
        @(posedge clk);
        #1;
        n_checks++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL divu_pulse: got %b want 0", valid_out); end
        n_checks++;
        if (ready_out !== 1'b1) begin n_fail++; $display("FAIL divu_idle: got %b want 1", ready_out); end
        n_checks++;
        if (c_out !== 32'd14) begin n_fail++; $display("FAIL divu_hold: got %h want 0000000e", c_out); end
    endtask

    // Watch a window of cycles and return how many had valid_out high
    task automatic count_valid(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (valid_out) seen++;
        end
    endtask

    task automatic test_flush;
        int seen;
        // Flush in CALC, ten edges after acceptance
        @(negedge clk);
        instr = enc(F_DIVU); a_in = 32'd100; b_in = 32'd7; valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_checks++;
        if (ready_out !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", ready_out); end
        n_checks++;
        if (c_out !== 32'd14) begin n_fail++; $display("FAIL flush_cout: got %h want 0000000e", c_out); end
        count_valid(40, seen);
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL flush_novalid: got %0d want 0", seen); end

        // Flush together with a request in IDLE: request is dropped
        @(negedge clk);
        instr = enc(F_DIV); a_in = 32'd9; b_in = 32'd0; valid_in = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0; flush = 1'b0;
        n_checks++;
        if (ready_out !== 1'b1) begin n_fail++; $display("FAIL flush_idle_ready: got %b want 1", ready_out); end
        count_valid(5, seen);
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL flush_idle_novalid: got %0d want 0", seen); end
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        instr = enc(F_DIVU); a_in = 32'd100; b_in = 32'd7; valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ready_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", ready_out); end
        n_checks++;
        if (c_out !== 32'h0) begin n_fail++; $display("FAIL rstmid_cout: got %h want 00000000", c_out); end
        @(negedge clk);
        rst_n = 1'b1;
        count_valid(40, seen);
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL rstmid_novalid: got %0d want 0", seen); end
    endtask

    task automatic test_signed;
        logic [31:0] res;
        int lat, busy;
        vec_t v[9] = '{
            '{F_REM,  32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFFE, 8'd33},
            '{F_DIV,  32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFF2, 8'd33},
            '{F_DIV,  32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 8'd33},
            '{F_REM,  32'd7,         32'hFFFF_FFFE,  32'h0000_0001, 8'd33},
            '{F_DIVU, 32'hFFFF_FF9C, 32'd7,          32'h2492_4916, 8'd33},
            '{F_REMU, 32'hFFFF_FF9C, 32'd7,          32'h0000_0002, 8'd33},
            '{F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 8'd33},
            '{F_REM,  32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 8'd33},
            '{F_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'h0000_000E, 8'd33}
        };
        for (int i = 0; i < 9; i++) begin
            run_op(enc(v[i].f3), v[i].a, v[i].b, res, lat, busy);
            n_checks++;
            if (res !== v[i].exp || lat != int'(v[i].lat)) begin
                n_fail++;
                $display("FAIL signed[%0d]: got %h lat %0d want %h lat %0d",
                         i, res, lat, v[i].exp, v[i].lat);
            end
        end
    endtask

    task automatic test_special;
        logic [31:0] res;
        int lat, busy;
        vec_t v[6] = '{
            '{F_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 8'd1},
            '{F_REMU, 32'd5,         32'd0,         32'h0000_0005, 8'd1},
            '{F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 8'd1},
            '{F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 8'd1},
            '{F_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 8'd1},
            '{F_REM,  32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 8'd1}
        };
        for (int i = 0; i < 6; i++) begin
            run_op(enc(v[i].f3), v[i].a, v[i].b, res, lat, busy);
            n_checks++;
            if (res !== v[i].exp || lat != int'(v[i].lat)) begin
                n_fail++;
                $display("FAIL special[%0d]: got %h lat %0d want %h lat %0d",
                         i, res, lat, v[i].exp, v[i].lat);
            end
        end
    endtask

    task automatic test_illegal;
        int seen;
        logic [31:0] ins[4] = '{
            32'b0000000_00010_00001_000_00011_0110011,   // ADD
            32'b0000001_00010_00001_000_00011_0110011,   // MUL
            32'b0100000_00010_00001_100_00011_0110011,   // wrong funct7
            32'b0000001_00010_00001_100_00011_0111011    // wrong opcode
        };
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            instr = ins[i]; a_in = 32'd50; b_in = 32'd0; valid_in = 1'b1;
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            n_checks++;
            if (ready_out !== 1'b1) begin
                n_fail++; $display("FAIL illegal_ready[%0d]: got %b want 1", i, ready_out);
            end
            count_valid(36, seen);
            n_checks++;
            if (seen != 0 || c_out !== 32'hFFFF_FF9C) begin
                n_fail++;
                $display("FAIL illegal_quiet[%0d]: got %0d pulses c_out %h want 0 pulses ffffff9c",
                         i, seen, c_out);
            end
        end
    endtask

    task automatic test_reuse;
        logic [31:0] res;
        int lat, busy, want_lat;
`ifdef DIV_RESULT_REUSE_EN
        want_lat = 1;
`else
        want_lat = 33;
`endif
        run_op(enc(F_DIVU), 32'd1000, 32'd33, res, lat, busy);
        n_checks++;
        if (res !== 32'd30 || lat != 33) begin
            n_fail++; $display("FAIL reuse_first: got %h lat %0d want 0000001e lat 33", res, lat);
        end
        run_op(enc(F_REMU), 32'd1000, 32'd33, res, lat, busy);
        n_checks++;
        if (res !== 32'd10 || lat != want_lat) begin
            n_fail++;
            $display("FAIL reuse_second: got %h lat %0d want 0000000a lat %0d", res, lat, want_lat);
        end
        // Different signedness never hits the cache
        run_op(enc(F_DIV), 32'd1000, 32'd33, res, lat, busy);
        n_checks++;
        if (res !== 32'd30 || lat != 33) begin
            n_fail++; $display("FAIL reuse_signed: got %h lat %0d want 0000001e lat 33", res, lat);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    task automatic test_random;
        logic [31:0] res, a, b, exp;
        logic [2:0]  f3;
        int lat, busy;
        for (int i = 0; i < 250; i++) begin
            a   = pick();
            b   = pick();
            f3  = {1'b1, 2'($urandom_range(0, 3))};
            exp = model(f3, a, b);
            run_op(enc(f3), a, b, res, lat, busy);
            n_checks++;
            if (res !== exp || lat == 0) begin
                n_fail++;
                $display("FAIL random[%0d] f3=%b a=%h b=%h: got %h lat %0d want %h",
                         i, f3, a, b, res, lat, exp);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_divu();
        test_flush();
        test_reset_mid();
        test_signed();
        test_special();
        test_illegal();
        test_reuse();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
